mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one 32-bit single-outstanding memory port between icache line refill and dcache word accesses.
- Icache refills are 256-bit lines (8 words): the block runs 8 sequential word reads and assembles the line.
- Dcache accesses are single-word reads or byte-masked writes.
- Sits between icache/dcache and data memory / bus bridge. Fixed dcache priority with a starvation guard for icache.

Parameters:
- LINE_WORDS, 8, words per icache line; ic_ret_data width = 32*LINE_WORDS.
- STARVE_LIMIT, 4, consecutive dcache grants while icache waits before icache is forced to win; range 1..15.

Ports:
- clk  in  1  clock; single clock domain, all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- ic_rd_req  in  1  icache refill request; sampled only in IDLE.
- ic_rd_addr  in  32  refill address; bits [4:0] ignored (line-aligned).
- ic_ret_valid  out  1  one-cycle pulse: full line available.
- ic_ret_data  out  256  assembled line; word k at [32k+31:32k].
- dc_valid  in  1  dcache request; held until dc_data_ok.
- dc_op  in  1  1 = write, 0 = read.
- dc_addr  in  32  word address; bits [1:0] passed through.
- dc_wstrb  in  4  byte write strobes.
- dc_wdata  in  32  write data.
- dc_rdata  out  32  read data; valid only with dc_data_ok on a read.
- dc_data_ok  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable.
- mem_addr  out  32  memory address.
- mem_wstrb  out  4  byte strobes; 0000 on reads.
- mem_wdata  out  32  write data.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  read data valid; earliest one cycle after acceptance.
- mem_rdata  in  32  read data.

Behaviour:
- States: IDLE, IC_REQ, IC_WAIT, IC_RET, DC_REQ, DC_WAIT.
- Reset, including mid-operation: state IDLE, beat counter 0, streak counter 0. All outputs 0, including ic_ret_data. No pulses are emitted for the aborted transfer; partial beats are discarded.
- IDLE grant decision:
  - Both requests high: dcache wins unless streak == STARVE_LIMIT.
  - Icache grant: latch base = {ic_rd_addr[31:5], 5'b0}, clear streak, clear beat counter, go to IC_REQ.
  - Dcache grant: latch op/addr/wstrb/wdata. Increment streak (saturating) if ic_rd_req is high, else clear streak. Go to DC_REQ.
  - ic_rd_req may drop after grant; the refill still completes.
- IC_REQ:
  - Drive mem_req=1, mem_we=0, mem_addr = base + 4*beat, mem_wstrb=0.
  - Hold outputs until mem_ready, then go to IC_WAIT.
- IC_WAIT:
  - On mem_rvalid, write mem_rdata into line word[beat].
  - If beat == LINE_WORDS-1, go to IC_RET; else increment beat and go to IC_REQ.
- IC_RET: ic_ret_valid=1 for exactly one cycle, then IDLE. ic_ret_data is registered and holds until the next refill overwrites it.
- DC_REQ:
  - Drive mem_req=1 with the latched fields (mem_we = op).
  - Write with mem_ready: dc_data_ok=1 combinationally in the same cycle, next state IDLE.
  - Read with mem_ready: next state DC_WAIT.
- DC_WAIT: on mem_rvalid, dc_data_ok=1 and dc_rdata = mem_rdata (combinational, same cycle), next state IDLE.
- mem_req is 0 in IDLE, IC_WAIT, DC_WAIT and IC_RET. The bus never carries two outstanding requests.
- mem_rvalid outside IC_WAIT/DC_WAIT is ignored.
- dc_valid still high in IDLE after a completion is treated as a new request. The dcache must drop dc_valid the cycle after dc_data_ok unless it issues a new access.
- Latency with mem_ready=1 and 1-cycle read return, grant at cycle 0 (IDLE):
  - dcache write: ok at cycle 1.
  - dcache read: ok at cycle 2.
  - icache refill: beat k issued at cycle 1+2k, returned at cycle 2+2k; ic_ret_valid at cycle 17; IDLE at cycle 18.
- A refill, once granted, is never preempted by dcache.
- Address wrap: base + 4*beat computed in 32 bits, modulo 2^32.

Test Plan:
- Dcache write, addr 0x1C000100, wstrb 0101, wdata 0xA5A55A5A, mem_ready=1 -> one mem beat with we=1 and those fields; dc_data_ok at cycle 1; no icache activity.
- Icache refill at ic_rd_addr 0x1C00001C, memory returns word k = 0x1000+k -> addresses 0x1C000000..0x1C00001C in order; ic_ret_valid at cycle 17; ic_ret_data word k = 0x1000+k.
- ic_rd_req and dc_valid (read) asserted together in IDLE -> dcache served first; refill starts the cycle after dc_data_ok.
- ic_rd_req held high, dc_valid re-asserted back-to-back, STARVE_LIMIT=4 -> exactly 4 dcache accesses, then the icache refill, then dcache again.
- mem_ready low 3 cycles on beat 2 -> mem_req, mem_addr (0x1C000008) and strobes held stable; no beat skipped; ic_ret_valid delayed by 3 cycles.
- rst asserted during beat 5 of a refill -> next cycle all outputs 0 and state IDLE; no ic_ret_valid; stray mem_rvalid afterwards ignored; a new refill completes correctly.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-outstanding 32-bit memory port between icache refills and dcache accesses
module mem_arbiter #(
    parameter int LINE_WORDS   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ic_rd_req,
    input  logic [31:0]              ic_rd_addr,
    output logic                     ic_ret_valid,
    output logic [32*LINE_WORDS-1:0] ic_ret_data,
    input  logic                     dc_valid,
    input  logic                     dc_op,
    input  logic [31:0]              dc_addr,
    input  logic [3:0]               dc_wstrb,
    input  logic [31:0]              dc_wdata,
    output logic [31:0]              dc_rdata,
    output logic                     dc_data_ok,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [3:0]               mem_wstrb,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_ready,
    input  logic                     mem_rvalid,
    input  logic [31:0]              mem_rdata
);

    localparam int              BW         = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [BW-1:0]   LAST_BEAT  = BW'(LINE_WORDS - 1);
    localparam logic [3:0]      STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        IC_REQ,
        IC_WAIT,
        IC_RET,
        DC_REQ,
        DC_WAIT
    } state_t;

    state_t                    state_q;
    logic [BW-1:0]             beat_q;
    logic [3:0]                streak_q;
    logic [31:0]               base_q;
    logic                      dc_we_q;
    logic [31:0]               dc_addr_q;
    logic [3:0]                dc_wstrb_q;
    logic [31:0]               dc_wdata_q;
    logic [32*LINE_WORDS-1:0]  line_q;

    // dcache has priority unless icache has already lost STARVE_LIMIT grants in a row
    logic dc_wins;
    assign dc_wins = dc_valid && !(ic_rd_req && (streak_q == STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            streak_q   <= '0;
            base_q     <= '0;
            dc_we_q    <= 1'b0;
            dc_addr_q  <= '0;
            dc_wstrb_q <= '0;
            dc_wdata_q <= '0;
            line_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dc_wins) begin
                        dc_we_q    <= dc_op;
                        dc_addr_q  <= dc_addr;
                        dc_wstrb_q <= dc_wstrb;
                        dc_wdata_q <= dc_wdata;
                        if (ic_rd_req)
                            streak_q <= (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
                        else
                            streak_q <= '0;
                        state_q <= DC_REQ;
                    end else if (ic_rd_req) begin
                        base_q   <= ic_rd_addr & ~32'h1F;
                        streak_q <= '0;
                        beat_q   <= '0;
                        state_q  <= IC_REQ;
                    end
                end
                IC_REQ: begin
                    if (mem_ready)
                        state_q <= IC_WAIT;
                end
                IC_WAIT: begin
                    if (mem_rvalid) begin
                        line_q[32*beat_q +: 32] <= mem_rdata;
                        if (beat_q == LAST_BEAT) begin
                            state_q <= IC_RET;
                        end else begin
                            beat_q  <= beat_q + BW'(1);
                            state_q <= IC_REQ;
                        end
                    end
                end
                IC_RET: state_q <= IDLE;
                DC_REQ: begin
                    if (mem_ready)
                        state_q <= dc_we_q ? IDLE : DC_WAIT;
                end
                DC_WAIT: begin
                    if (mem_rvalid)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic ic_req_st;
    logic dc_req_st;
    logic dc_wait_st;
    assign ic_req_st  = (state_q == IC_REQ);
    assign dc_req_st  = (state_q == DC_REQ);
    assign dc_wait_st = (state_q == DC_WAIT);

    // Bus fields are forced to zero whenever no request is presented
    assign mem_req   = ic_req_st || dc_req_st;
    assign mem_we    = dc_req_st && dc_we_q;
    assign mem_addr  = ic_req_st ? (base_q + (32'(beat_q) << 2)) :
                       dc_req_st ? dc_addr_q : 32'h0;
    assign mem_wstrb = (dc_req_st && dc_we_q) ? dc_wstrb_q : 4'h0;
    assign mem_wdata = dc_req_st ? dc_wdata_q : 32'h0;

    assign dc_data_ok   = (dc_req_st && dc_we_q && mem_ready) || (dc_wait_st && mem_rvalid);
    assign dc_rdata     = (dc_wait_st && mem_rvalid) ? mem_rdata : 32'h0;
    assign ic_ret_valid = (state_q == IC_RET);
    assign ic_ret_data  = line_q;

endmodule
